// File: rtl/serial_parity_checker_if.sv
// Bundles the serial bit stream and status outputs of serial_parity_checker.
// The master side drives the stream and the slave side is the checker.
interface serial_parity_checker_if #(
  parameter int FRAME_LEN = 8
) ();
  localparam int CW = $clog2(FRAME_LEN + 1);

  logic          start;
  logic          bit_valid;
  logic          xor_in;
  logic          busy;
  logic [CW-1:0] bit_count;
  logic          parity_out;
  logic          done;
  logic          error;

  modport master (
    output start, bit_valid, xor_in,
    input  busy, bit_count, parity_out, done, error
  );

  modport slave (
    input  start, bit_valid, xor_in,
    output busy, bit_count, parity_out, done, error
  );
endinterface

// File: rtl/serial_parity_checker.sv
// Accumulates parity over FRAME_LEN serial data bits, then compares it with a
// trailing received parity bit and reports the result with a one-cycle done pulse.
module serial_parity_checker #(
  parameter int FRAME_LEN  = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_parity_checker_if.slave bus
);
  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          busy_q;
  logic          parity_q;
  logic          done_q;
  logic          error_q;
  logic          last_bit;

  assign count_d  = count_q + CW'(1);
  assign last_bit = (count_q == CW'(FRAME_LEN - 1));

  // parity_q already holds acc ^ ODD_PARITY, so the received bit compares against it directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q  <= DATA;
            count_q  <= '0;
            busy_q   <= 1'b1;
            parity_q <= ODD_PARITY;
            error_q  <= 1'b0;
          end
        end
        DATA: begin
          if (bus.bit_valid) begin
            parity_q <= parity_q ^ bus.xor_in;
            count_q  <= count_d;
            if (last_bit) begin
              state_q <= PAR;
            end
          end
        end
        PAR: begin
          if (bus.bit_valid) begin
            error_q <= (bus.xor_in != parity_q);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.bit_count  = count_q;
  assign bus.parity_out = parity_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Downstream consumer of the XOR/XNOR mux gate stage.
- Takes the gate's per-cycle XOR result as a serial bit stream and accumulates parity over a frame of FRAME_LEN data bits.
- Compares the accumulated parity against a trailing received parity bit and reports pass/fail with a one-cycle done pulse.
- Used for framed link checking and as the self-checking sink in gate-level benches.

Parameters:
- FRAME_LEN, 8, number of data bits per frame (legal range 2..255).
- ODD_PARITY, 0, 0 = even parity (expected bit = XOR of data bits); 1 = odd parity (expected bit = inverted XOR).
- CW, $clog2(FRAME_LEN+1), width of the bit counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new frame; sampled in IDLE only.
- bit_valid  input  1  xor_in is valid this cycle.
- xor_in  input  1  serial data bit (the XOR gate output).
- busy  output  1  high in DATA and PAR states.
- bit_count  output  CW  data bits accepted so far in the current frame.
- parity_out  output  1  running parity (ODD_PARITY applied); final value held after the frame.
- done  output  1  one-cycle pulse when the frame completes.
- error  output  1  parity mismatch flag; valid with done and held until the next start.

Behaviour:
- Reset: async on rst_n low; all outputs are 0 and the state is IDLE.
  - Reset mid-frame aborts the frame with no done pulse.
  - Release is synchronous to clk.
- States are IDLE, DATA, PAR and DONE. All outputs are registered.
- IDLE:
  - start=1 → DATA; bit_count←0; acc←0; error←0.
  - bit_valid is ignored in IDLE.
- DATA:
  - On bit_valid=1: acc←acc^xor_in; bit_count←bit_count+1.
  - When the accepted bit is bit number FRAME_LEN → PAR.
  - bit_valid=0 stalls: no state change, no count change. There is no timeout.
- PAR:
  - On bit_valid=1, xor_in is the received parity bit.
  - error ← (xor_in != (acc ^ ODD_PARITY)); → DONE.
  - bit_count stays at FRAME_LEN.
- DONE:
  - done=1 for exactly this one cycle; → IDLE unconditionally.
  - start asserted during DONE is ignored; it must be re-asserted in IDLE.
- parity_out = acc ^ ODD_PARITY, continuously registered.
  - Updates the cycle after each accepted data bit.
  - Not changed by the received parity bit.
  - Cleared to ODD_PARITY by start.
- Latency: done rises 1 cycle after the parity bit is accepted. A frame with no stalls occupies FRAME_LEN+2 cycles after start.
- start asserted in DATA, PAR or DONE is ignored; there is no restart mid-frame.
- Simultaneous start and bit_valid in IDLE: start is taken; that cycle's bit is NOT counted.
- bit_count never exceeds FRAME_LEN; wrap-around is impossible by construction.
- error and parity_out hold their values through IDLE until the next start or reset.

Test Plan:
- Reset: rst_n=0 mid-DATA (after 3 bits) → busy=0, bit_count=0, done=0, error=0 immediately (async); no done pulse follows.
- Even frame, FRAME_LEN=8:
  - Stimulus: bits 1,0,1,1,0,0,1,0 (four 1s), then parity bit 0.
  - Required: parity_out=0 after bit 8; done pulse 1 cycle after the parity bit; error=0; bit_count=8.
- Mismatch: same data, parity bit 1 → done=1 with error=1; error stays 1 in IDLE until the next start.
- Stall: bit_valid deasserted for 5 cycles after bit 4 → bit_count holds at 4, busy=1, no done; the frame completes normally afterwards.
- ODD_PARITY=1:
  - Stimulus: bits 1,1,1,0,0,0,0,0 (three 1s).
  - Required: parity_out=0; parity bit 0 → error=0; parity bit 1 → error=1.
- Start collision: start=1 with bit_valid=1, xor_in=1 in IDLE → bit not counted (bit_count=0 next cycle). Start pulsed during DATA → ignored, bit_count unaffected.
